// File: rtl/load_hazard_ctrl.sv
// Load-use hazard controller: tracks in-flight loads for LOAD_LAT cycles after EXE and
// stalls PC/IF-ID with ID/EXE bubbles until the loaded data can be forwarded.
module load_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] if_id_rs1_addr,
    input  logic [REG_W-1:0] if_id_rs2_addr,
    input  logic             if_id_rs1_used,
    input  logic             if_id_rs2_used,
    input  logic [REG_W-1:0] id_exe_rd_addr,
    input  logic             id_exe_read_mem,
    input  logic             pc_jump_confirm,
    input  logic             mem_wait,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             instruction_stall,
    output logic             id_exe_bubble,
    output logic             load_pending,
    output logic [CNT_W-1:0] load_stall_cnt
);

    // With LOAD_LAT=1 the chain is logically empty; one dummy slot is kept and never loaded.
    localparam int   NS      = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic HAS_TRK = (LOAD_LAT > 1);

    logic [NS-1:0]    slot_vld;
    logic [REG_W-1:0] slot_rd [NS];

    logic exe_load;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    assign exe_load = id_exe_read_mem && (id_exe_rd_addr != '0);

    always_comb begin
        rs1_hit = exe_load && (if_id_rs1_addr == id_exe_rd_addr);
        rs2_hit = exe_load && (if_id_rs2_addr == id_exe_rd_addr);
        for (int k = 0; k < NS; k++) begin
            if (slot_vld[k] && (slot_rd[k] == if_id_rs1_addr)) rs1_hit = 1'b1;
            if (slot_vld[k] && (slot_rd[k] == if_id_rs2_addr)) rs2_hit = 1'b1;
        end
        rs1_hit = rs1_hit && if_id_rs1_used && (if_id_rs1_addr != '0);
        rs2_hit = rs2_hit && if_id_rs2_used && (if_id_rs2_addr != '0);
        hazard  = rs1_hit || rs2_hit;
    end

    always_comb begin
        pc_stall          = 1'b0;
        instruction_stall = 1'b0;
        id_exe_bubble     = 1'b0;
        if (rst) begin
            pc_stall          = 1'b0;
        end else if (mem_wait) begin
            pc_stall          = 1'b1;
            instruction_stall = 1'b1;
        end else if (pc_jump_confirm) begin
            pc_stall          = 1'b0;
        end else if (hazard) begin
            pc_stall          = 1'b1;
            instruction_stall = 1'b1;
            id_exe_bubble     = 1'b1;
        end
    end

    assign load_pending = |slot_vld;

    // The tracker shifts whenever the pipeline moves, including on jumps and hazards.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
            for (int k = 0; k < NS; k++) slot_rd[k] <= '0;
        end else if (!mem_wait) begin
            for (int k = NS - 1; k > 0; k--) begin
                slot_vld[k] <= slot_vld[k-1];
                slot_rd[k]  <= slot_rd[k-1];
            end
            slot_vld[0] <= HAS_TRK && exe_load;
            slot_rd[0]  <= HAS_TRK ? id_exe_rd_addr : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            load_stall_cnt <= '0;
        end else if (id_exe_bubble && (load_stall_cnt != '1)) begin
            load_stall_cnt <= load_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// Directed bench for load_hazard_ctrl: three instances (LOAD_LAT 2, 3 and 1 with a
// 2-bit counter) share one stimulus set; each scenario checks the relevant instance.
module tb_load_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, read_mem, jump, mem_wait, cnt_clr;

    logic        a_pc, a_is, a_bub, a_pend;
    logic [15:0] a_cnt;
    logic        b_pc, b_is, b_bub, b_pend;
    logic [15:0] b_cnt;
    logic        c_pc, c_is, c_bub, c_pend;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr(rs1), .if_id_rs2_addr(rs2),
        .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
        .id_exe_rd_addr(rd), .id_exe_read_mem(read_mem),
        .pc_jump_confirm(jump), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .pc_stall(a_pc), .instruction_stall(a_is), .id_exe_bubble(a_bub),
        .load_pending(a_pend), .load_stall_cnt(a_cnt));

    load_hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr(rs1), .if_id_rs2_addr(rs2),
        .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
        .id_exe_rd_addr(rd), .id_exe_read_mem(read_mem),
        .pc_jump_confirm(jump), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .pc_stall(b_pc), .instruction_stall(b_is), .id_exe_bubble(b_bub),
        .load_pending(b_pend), .load_stall_cnt(b_cnt));

    load_hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr(rs1), .if_id_rs2_addr(rs2),
        .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
        .id_exe_rd_addr(rd), .id_exe_read_mem(read_mem),
        .pc_jump_confirm(jump), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .pc_stall(c_pc), .instruction_stall(c_is), .id_exe_bubble(c_bub),
        .load_pending(c_pend), .load_stall_cnt(c_cnt));

    task automatic idle();
        rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
        rd = 0; read_mem = 0; jump = 0; mem_wait = 0; cnt_clr = 0;
    endtask

    // Advance one clock; inputs may be changed afterwards for the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        rs1 = 3; rs1_used = 1; rd = 3; read_mem = 1;
        step();
        #1;
        n_checks++;
        if ({a_pc, a_is, a_bub} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outputs got=%b want=000", {a_pc, a_is, a_bub});
        end
        n_checks++;
        if (a_cnt !== 16'd0 || a_pend !== 1'b0 || b_pend !== 1'b0) begin
            n_fail++; $display("FAIL reset_state cnt=%0d pend_a=%b pend_b=%b want 0/0/0", a_cnt, a_pend, b_pend);
        end
        do_reset();
    endtask

    task automatic test_basic_lat2();
        do_reset();
        rd = 5; read_mem = 1; rs1 = 5; rs1_used = 1;
        #1;
        n_checks++;
        if ({a_pc, a_is, a_bub} !== 3'b111 || {c_pc, c_bub} !== 2'b11) begin
            n_fail++; $display("FAIL basic_c0 a=%b c=%b want a=111 c=11", {a_pc, a_is, a_bub}, {c_pc, c_bub});
        end
        step();
        rd = 0; read_mem = 0;
        #1;
        n_checks++;
        if ({a_pc, a_is, a_bub, a_pend} !== 4'b1111 || {c_pc, c_bub, c_pend} !== 3'b000) begin
            n_fail++; $display("FAIL basic_c1 a=%b c=%b want a=1111 c=000", {a_pc, a_is, a_bub, a_pend}, {c_pc, c_bub, c_pend});
        end
        step();
        n_checks++;
        if ({a_pc, a_is, a_bub, a_pend} !== 4'b0000 || a_cnt !== 16'd2) begin
            n_fail++; $display("FAIL basic_c2 outs=%b cnt=%0d want 0000 cnt=2", {a_pc, a_is, a_bub, a_pend}, a_cnt);
        end
    endtask

    task automatic test_x0_and_unused();
        do_reset();
        rd = 0; read_mem = 1; rs1 = 0; rs1_used = 1;
        #1;
        n_checks++;
        if ({a_pc, a_bub, b_pc, c_pc} !== 4'b0000) begin
            n_fail++; $display("FAIL x0_stall got=%b want=0000", {a_pc, a_bub, b_pc, c_pc});
        end
        step();
        n_checks++;
        if ({a_pend, b_pend} !== 2'b00) begin
            n_fail++; $display("FAIL x0_pending got=%b want=00", {a_pend, b_pend});
        end
        rd = 7; read_mem = 1; rs1 = 1; rs1_used = 1; rs2 = 7; rs2_used = 0;
        #1;
        n_checks++;
        if ({a_pc, a_is, a_bub, c_pc} !== 4'b0000) begin
            n_fail++; $display("FAIL rs2_unused got=%b want=0000", {a_pc, a_is, a_bub, c_pc});
        end
    endtask

    task automatic test_mem_wait_lat3();
        bit [2:0] exp_sib [5] = '{3'b111, 3'b110, 3'b111, 3'b111, 3'b000};
        do_reset();
        rd = 9; read_mem = 1; rs1 = 9; rs1_used = 1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin rd = 0; read_mem = 0; mem_wait = 1; end
            if (c == 2) mem_wait = 0;
            #1;
            n_checks++;
            if ({b_pc, b_is, b_bub} !== exp_sib[c]) begin
                n_fail++; $display("FAIL memwait_c%0d got=%b want=%b", c, {b_pc, b_is, b_bub}, exp_sib[c]);
            end
            if (c < 4) step();
        end
        n_checks++;
        if (b_cnt !== 16'd3) begin
            n_fail++; $display("FAIL memwait_cnt got=%0d want=3", b_cnt);
        end
    endtask

    task automatic test_jump();
        do_reset();
        rd = 4; read_mem = 1; rs1 = 4; rs1_used = 1; jump = 1;
        #1;
        n_checks++;
        if ({a_pc, a_is, a_bub, c_pc} !== 4'b0000) begin
            n_fail++; $display("FAIL jump_stall got=%b want=0000", {a_pc, a_is, a_bub, c_pc});
        end
        step();
        idle();
        #1;
        n_checks++;
        if (a_pend !== 1'b1 || a_cnt !== 16'd0) begin
            n_fail++; $display("FAIL jump_pending pend=%b cnt=%0d want 1 cnt=0", a_pend, a_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_stall [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        rd = 5; read_mem = 1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin rd = 8; rs1 = 5; rs1_used = 1; rs2 = 8; rs2_used = 1; end
            if (c == 2) begin rd = 0; read_mem = 0; end
            #1;
            n_checks++;
            if (b_pc !== exp_stall[c] || b_bub !== exp_stall[c]) begin
                n_fail++; $display("FAIL b2b_c%0d stall=%b bub=%b want %b", c, b_pc, b_bub, exp_stall[c]);
            end
            if (c < 4) step();
        end
        n_checks++;
        if (b_pend !== 1'b0 || b_cnt !== 16'd3) begin
            n_fail++; $display("FAIL b2b_end pend=%b cnt=%0d want 0 cnt=3", b_pend, b_cnt);
        end
    endtask

    task automatic test_saturation();
        bit [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        rd = 3; read_mem = 1; rs1 = 3; rs1_used = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (c_cnt !== exp_cnt[c]) begin
                n_fail++; $display("FAIL sat_cnt_%0d got=%0d want=%0d", c, c_cnt, exp_cnt[c]);
            end
        end
        idle();
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        #1;
        n_checks++;
        if (c_cnt !== 2'd0 || a_cnt !== 16'd0) begin
            n_fail++; $display("FAIL cnt_clr c=%0d a=%0d want 0/0", c_cnt, a_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        rd = 6; read_mem = 1; rs1 = 6; rs1_used = 1;
        step();
        rd = 0; read_mem = 0;
        #1;
        n_checks++;
        if ({a_pc, a_pend} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_pre got=%b want=11", {a_pc, a_pend});
        end
        rst = 1;
        #1;
        n_checks++;
        if ({a_pc, a_is, a_bub, b_pc, b_is, b_bub} !== 6'b000000) begin
            n_fail++; $display("FAIL rstmid_outs got=%b want=000000", {a_pc, a_is, a_bub, b_pc, b_is, b_bub});
        end
        step();
        rst = 0;
        rs1 = 2;
        #1;
        n_checks++;
        if ({a_pc, a_bub, a_pend, b_pc, b_pend} !== 5'b00000) begin
            n_fail++; $display("FAIL rstmid_post got=%b want=00000", {a_pc, a_bub, a_pend, b_pc, b_pend});
        end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_basic_lat2();
        test_x0_and_unused();
        test_mem_wait_lat3();
        test_jump();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
